// File: rtl/buzzer_tone_sequencer_if.sv
// buzzer_tone_sequencer_if: Avalon-MM slave port bundle for the tone sequencer.
interface buzzer_tone_sequencer_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/buzzer_tone_sequencer.sv
// buzzer_tone_sequencer: FIFO-fed square-wave note player with sticky done/overflow flags.
module buzzer_tone_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int TICK_DIV   = 1000
) (
    input  logic                     clk,
    input  logic                     reset,
    buzzer_tone_sequencer_if.slave   bus,
    output logic                     buzzer,
    output logic                     irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;
    state_t        state_q, state_d;
    logic [31:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0] count_q, count_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [15:0]   dur_q, dur_d, tone_q, tone_d, h_q, h_d, d_q, d_d;
    logic          buzz_q, buzz_d, enable_q, enable_d, irq_en_q, irq_en_d;
    logic          done_q, done_d, ovf_q, ovf_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          we, flush, full, empty, push, push_ok, pop, tick_end, note_end;
    always_comb begin
        we       = bus.chipselect && !bus.write_n;
        flush    = we && bus.address == 2'd1 && bus.writedata[1];
        full     = count_q == CW'(FIFO_DEPTH);
        empty    = count_q == '0;
        push     = we && bus.address == 2'd0 && !flush;
        push_ok  = push && !full;
        tick_end = tick_q == TW'(TICK_DIV - 1);
        note_end = state_q == PLAY && tick_end && dur_q == d_q - 16'd1;
        state_d  = state_q;
        tick_d   = tick_q;
        dur_d    = dur_q;
        tone_d   = tone_q;
        buzz_d   = buzz_q;
        pop      = 1'b0;
        case (state_q)
            IDLE: begin
                pop     = enable_q && !empty;
                state_d = pop ? LOAD : IDLE;
            end
            LOAD: begin
                tick_d  = '0;
                dur_d   = '0;
                tone_d  = '0;
                buzz_d  = 1'b0;
                pop     = d_q == '0 && enable_q && !empty;
                state_d = d_q != '0 ? PLAY : pop ? LOAD : IDLE;
            end
            PLAY: begin
                tick_d = tick_end ? '0 : tick_q + TW'(1);
                dur_d  = tick_end ? dur_q + 16'd1 : dur_q;
                tone_d = h_q == '0 || tone_q == h_q - 16'd1 ? '0 : tone_q + 16'd1;
                buzz_d = h_q != '0 && tone_q == h_q - 16'd1 ? !buzz_q : buzz_q;
                if (note_end) begin
                    buzz_d  = 1'b0;
                    pop     = enable_q && !empty;
                    state_d = pop ? LOAD : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Flush overrides everything the sequencer decided this cycle.
        if (flush) begin
            state_d = IDLE;
            pop     = 1'b0;
            buzz_d  = 1'b0;
            tick_d  = '0;
            dur_d   = '0;
            tone_d  = '0;
        end
        wp_d     = flush ? '0 : wp_q + AW'(push_ok);
        rp_d     = flush ? '0 : rp_q + AW'(pop);
        count_d  = flush ? '0 : count_q + CW'(push_ok) - CW'(pop);
        {d_d, h_d} = pop ? mem_q[rp_q] : {d_q, h_q};
        enable_d = we && bus.address == 2'd1 ? bus.writedata[0] : enable_q;
        irq_en_d = we && bus.address == 2'd1 ? bus.writedata[2] : irq_en_q;
        done_d   = (done_q || (note_end && empty && !flush)) && !(we && bus.address == 2'd2 && bus.writedata[0]);
        ovf_d    = (ovf_q || (push && full)) && !(we && bus.address == 2'd2 && bus.writedata[1]);
        rdata_d  = bus.address == 2'd0 ? {23'b0, ovf_q, 4'(count_q), 1'b0, empty, full, state_q != IDLE} :
                   bus.address == 2'd1 ? {29'b0, irq_en_q, 1'b0, enable_q} :
                   bus.address == 2'd2 ? {31'b0, done_q} : 32'b0;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            wp_q     <= '0;
            rp_q     <= '0;
            count_q  <= '0;
            tick_q   <= '0;
            dur_q    <= '0;
            tone_q   <= '0;
            h_q      <= '0;
            d_q      <= '0;
            buzz_q   <= 1'b0;
            enable_q <= 1'b0;
            irq_en_q <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            wp_q     <= wp_d;
            rp_q     <= rp_d;
            count_q  <= count_d;
            tick_q   <= tick_d;
            dur_q    <= dur_d;
            tone_q   <= tone_d;
            h_q      <= h_d;
            d_q      <= d_d;
            buzz_q   <= buzz_d;
            enable_q <= enable_d;
            irq_en_q <= irq_en_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
            rdata_q  <= rdata_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wp_q] <= bus.writedata;
    end
    assign bus.readdata = rdata_q;
    assign buzzer       = buzz_q;
    assign irq          = done_q && irq_en_q;
endmodule
